pmem_resp: RTL

Memory responder for the single-cycle RV64 core: serves the core's instruction fetch (pc → inst) and its store port (address, data, memwrite) from one word-organised memory array based at 0x8000_0000. Stores are captured into a small write buffer and drained into the single array write port, which a program-image loader can claim with priority. Fetches see buffered stores through youngest-first forwarding. Illegal accesses are dropped and raise a sticky error.

---
 rtl/pmem_resp.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pmem_resp.sv
// pmem_resp: instruction-fetch / store responder for the single-cycle RV64 core.
// Stores queue in a small write buffer that drains into the array; fetches forward youngest-first.
`timescale 1ns/1ps
module pmem_resp #(
   parameter logic [63:0] BASE        = 64'h0000_0000_8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned WB_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] pc,
   output logic [31:0] inst,
   input  logic [63:0] address,
   input  logic [63:0] data,
   input  logic        memwrite,
   input  logic        ld_valid,
   input  logic [63:0] ld_addr,
   input  logic [63:0] ld_data,
   output logic        wb_empty,
   output logic        wb_full,
   output logic        err,
   output logic [63:0] err_addr
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam int unsigned PW   = $clog2(WB_DEPTH);
   localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

   // Below-BASE addresses wrap to huge offsets, so a single unsigned compare covers both bounds.
   function automatic logic in_range(input logic [63:0] a);
      return (a - BASE) < SPAN;
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
      return AW'((a - BASE) >> 3);
   endfunction

   logic [63:0]   mem_q     [DEPTH_WORDS];
   logic [AW-1:0] wb_idx_q  [WB_DEPTH];
   logic [63:0]   wb_data_q [WB_DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   count_q, count_d;
   logic          err_q, err_d;
   logic [63:0]   err_addr_q, err_addr_d;

   logic          buf_full;
   logic          drain;
   logic          push;
   logic          st_err;
   logic          pc_bad;
   logic          fetch_err;
   logic [AW-1:0] st_idx;
   logic [AW-1:0] pc_idx;
   logic [AW-1:0] ld_idx;
   logic          ld_hit;
   logic [63:0]   fetch_word;
   logic [PW-1:0] slot;

   assign st_idx    = word_idx(address);
   assign pc_idx    = word_idx(pc);
   assign ld_idx    = word_idx(ld_addr);
   assign ld_hit    = ld_valid && in_range(ld_addr);
   assign buf_full  = (count_q == (PW+1)'(WB_DEPTH));
   // Reset discards pending entries, so no drain may happen in a reset cycle.
   assign drain     = !rst && (count_q != '0) && !ld_valid;
   assign push      = !rst && memwrite && in_range(address) && (address[2:0] == 3'b000)
                      && (!buf_full || drain);
   assign st_err    = !rst && memwrite && !push;
   assign pc_bad    = !in_range(pc) || (pc[1:0] != 2'b00);
   assign fetch_err = !rst && pc_bad;

   always_comb begin
      // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
      fetch_word = mem_q[pc_idx];
      slot       = '0;
      // Walk oldest to youngest so the last match (youngest store) wins.
      for (int i = 0; i < int'(WB_DEPTH); i++) begin
         slot = head_q + PW'(i);
         if (((PW+1)'(i) < count_q) && (wb_idx_q[slot] == pc_idx))
            fetch_word = wb_data_q[slot];
      end
      inst = pc_bad ? 32'h0000_0000 : (pc[2] ? fetch_word[63:32] : fetch_word[31:0]);
   end

   always_comb begin
      head_d     = drain ? head_q + PW'(1) : head_q;
      tail_d     = push  ? tail_q + PW'(1) : tail_q;
      count_d    = count_q + (PW+1)'(push) - (PW+1)'(drain);
      err_d      = err_q;
      err_addr_d = err_addr_q;
      // Store errors take precedence over a fetch error in the same cycle.
      if (st_err) begin
         err_d = 1'b1;
         if (!err_q) err_addr_d = address;
      end else if (fetch_err) begin
         err_d = 1'b1;
         if (!err_q) err_addr_d = pc;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // NOTE: buffer payload and the array carry no reset; validity comes from count_q and the loader.
   always_ff @(posedge clk) begin
      if (push) begin
         wb_idx_q[tail_q]  <= st_idx;
         wb_data_q[tail_q] <= data;
      end
   end

   // The loader owns the single write port; a blocked drain simply retries next cycle.
   always_ff @(posedge clk) begin
      if (ld_hit)
         mem_q[ld_idx] <= ld_data;
      else if (drain)
         mem_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
   end

   assign wb_empty = (count_q == '0);
   assign wb_full  = buf_full;
   assign err      = err_q;
   assign err_addr = err_addr_q;

endmodule
